ldpc_3gpp_dec_cnode_p_min_search: RTL

// - Serial partial min search feeding the check node 2-way merge engine. Per check row segment it accepts
//   one signed vnode LLR per cycle, framed by isop/ieop.
// - Tracks min1/min2 of |LLR|, the column of min1, sign parity and degree.
// - Emits one vn_min_t-compatible record (min1, min2, min1_col) one cycle after the ieop sample.
//

---
 rtl/ldpc_3gpp_dec_cnode_p_min_search.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ldpc_3gpp_dec_cnode_p_min_search.sv
// Serial partial min search: min1/min2 of |LLR|, min1 column, sign parity and degree per row segment.
// Optional offset min-sum output stage: define LDPC_3GPP_DEC_CNODE_MIN_SEARCH_OFFSET_EN.
module ldpc_3gpp_dec_cnode_p_min_search #(
  parameter int unsigned pLLR_W  = 4,
  parameter int unsigned pNODE_W = 8
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               ival,
  input  logic               isop,
  input  logic               ieop,
  input  logic [pLLR_W-1:0]  ivn,
  input  logic [pNODE_W-1:0] icol,
  output logic               oval,
  output logic [pLLR_W-2:0]  omin1,
  output logic [pLLR_W-2:0]  omin2,
  output logic [pNODE_W-1:0] omin1_col,
  output logic               osign,
  output logic [pNODE_W-1:0] odeg
);

  localparam int unsigned MAG_W = pLLR_W - 1;
  localparam logic [MAG_W-1:0]   MAXM    = '1;
  localparam logic [pNODE_W-1:0] DEG_MAX = '1;
  localparam logic [pLLR_W-1:0]  LLR_MIN = {1'b1, {(pLLR_W-1){1'b0}}};

  typedef enum logic {IDLE, ACC} state_t;

  state_t             state_q, state_d;
  logic [MAG_W-1:0]   min1_q, min1_d, min2_q, min2_d;
  logic [pNODE_W-1:0] col_q, col_d, deg_q, deg_d;
  logic               sign_q, sign_d;

  logic               oval_q, oval_d;
  logic [MAG_W-1:0]   omin1_q, omin1_d, omin2_q, omin2_d;
  logic [pNODE_W-1:0] ocol_q, ocol_d, odeg_q, odeg_d;
  logic               osign_q, osign_d;

  logic [pLLR_W-1:0]  neg_vn;
  logic [MAG_W-1:0]   mag;
  logic [MAG_W-1:0]   n_min1, n_min2;
  logic [pNODE_W-1:0] n_col, n_deg;
  logic               n_sign;
  logic               take;

  function automatic logic [MAG_W-1:0] out_mag(input logic [MAG_W-1:0] x);
`ifdef LDPC_3GPP_DEC_CNODE_MIN_SEARCH_OFFSET_EN
    out_mag = (x == '0) ? '0 : x - MAG_W'(1);
`else
    out_mag = x;
`endif
  endfunction

  // saturated magnitude: the most negative code maps to MAXM
  always_comb begin
    neg_vn = (~ivn) + pLLR_W'(1);
    if (!ivn[pLLR_W-1])     mag = MAG_W'(ivn);
    else if (ivn == LLR_MIN) mag = MAXM;
    else                     mag = MAG_W'(neg_vn);
  end

  // next accumulator value including the current sample
  always_comb begin
    n_min1 = min1_q;
    n_min2 = min2_q;
    n_col  = col_q;
    n_sign = sign_q;
    n_deg  = deg_q;
    if (isop) begin
      n_min1 = mag;
      n_min2 = MAXM;
      n_col  = icol;
      n_sign = ivn[pLLR_W-1];
      n_deg  = pNODE_W'(1);
    end else begin
      if (mag < min1_q) begin
        n_min2 = min1_q;
        n_min1 = mag;
        n_col  = icol;
      end else if (mag < min2_q) begin
        n_min2 = mag;
      end
      n_sign = sign_q ^ ivn[pLLR_W-1];
      n_deg  = (deg_q == DEG_MAX) ? deg_q : deg_q + pNODE_W'(1);
    end
  end

  // FSM next state, accumulator and output register loads
  always_comb begin
    state_d = state_q;
    min1_d  = min1_q;
    min2_d  = min2_q;
    col_d   = col_q;
    sign_d  = sign_q;
    deg_d   = deg_q;
    oval_d  = 1'b0;
    omin1_d = omin1_q;
    omin2_d = omin2_q;
    ocol_d  = ocol_q;
    osign_d = osign_q;
    odeg_d  = odeg_q;
    take    = ival && (isop || (state_q == ACC));
    if (take) begin
      if (ieop) begin
        state_d = IDLE;
        oval_d  = 1'b1;
        omin1_d = out_mag(n_min1);
        omin2_d = out_mag(n_min2);
        ocol_d  = n_col;
        osign_d = n_sign;
        odeg_d  = n_deg;
      end else begin
        state_d = ACC;
        min1_d  = n_min1;
        min2_d  = n_min2;
        col_d   = n_col;
        sign_d  = n_sign;
        deg_d   = n_deg;
      end
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q <= IDLE;
      min1_q  <= '0;
      min2_q  <= '0;
      col_q   <= '0;
      sign_q  <= 1'b0;
      deg_q   <= '0;
      oval_q  <= 1'b0;
      omin1_q <= '0;
      omin2_q <= '0;
      ocol_q  <= '0;
      osign_q <= 1'b0;
      odeg_q  <= '0;
    end else if (iclkena) begin
      state_q <= state_d;
      min1_q  <= min1_d;
      min2_q  <= min2_d;
      col_q   <= col_d;
      sign_q  <= sign_d;
      deg_q   <= deg_d;
      oval_q  <= oval_d;
      omin1_q <= omin1_d;
      omin2_q <= omin2_d;
      ocol_q  <= ocol_d;
      osign_q <= osign_d;
      odeg_q  <= odeg_d;
    end
  end

  assign oval      = oval_q;
  assign omin1     = omin1_q;
  assign omin2     = omin2_q;
  assign omin1_col = ocol_q;
  assign osign     = osign_q;
  assign odeg      = odeg_q;

endmodule
